imem_loader_ctrl: RTL and testbench

- Owns the single address/write path into instruction memory and sequences it between two users: a boot/debug loader that streams words into IMEM, and core instruction fetch.
- Holds the core stalled while a program image is loaded, then hands IMEM over to fetch.
- Sits between the external loader interface, the core fetch stage and the IMEM array, which has a combinational read and a synchronous write.

---
 rtl/imem_loader_ctrl_pkg.sv | 6 +
 rtl/imem_loader_ctrl_if.sv | 33 +++
 rtl/imem_loader_ctrl.sv | 76 +++++++
 tb/tb_imem_loader_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_ctrl_pkg.sv
// imem_loader_ctrl_pkg: shared IMEM types and sizing
package imem_loader_ctrl_pkg;
  typedef logic [31:0] u32_t;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} imem_ctrl_state_t;
  localparam int IMEM_SIZE_WORDS = 256;
endpackage

// File: rtl/imem_loader_ctrl_if.sv
// imem_loader_ctrl_if: loader, fetch and IMEM port bundle of the IMEM loader controller
interface imem_loader_ctrl_if import imem_loader_ctrl_pkg::*; #(
  parameter int SIZE_WORDS = IMEM_SIZE_WORDS
) ();
  localparam int CW = $clog2(SIZE_WORDS) + 1;
  logic          load_start;
  logic          ld_valid;
  u32_t          ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          fetch_req;
  u32_t          fetch_addr;
  u32_t          fetch_data;
  logic          fetch_valid;
  logic          core_stall;
  u32_t          mem_addr;
  logic          mem_we;
  u32_t          mem_wdata;
  u32_t          mem_rdata;
  logic          load_done;
  logic          load_err;
  logic [CW-1:0] word_count;
  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
    output ld_ready, fetch_data, fetch_valid, core_stall, mem_addr, mem_we, mem_wdata,
           load_done, load_err, word_count
  );
  modport master (
    output load_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
    input  ld_ready, fetch_data, fetch_valid, core_stall, mem_addr, mem_we, mem_wdata,
           load_done, load_err, word_count
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: arbitrates the IMEM port between the image loader and core fetch
module imem_loader_ctrl import imem_loader_ctrl_pkg::*; #(
  parameter int SIZE_WORDS = IMEM_SIZE_WORDS,
  parameter bit AUTO_RUN   = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_ctrl_if.slave bus
);
  localparam int AW = $clog2(SIZE_WORDS);
  localparam int CW = AW + 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_RST  = AUTO_RUN ? S_RUN : S_IDLE;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, done_q, done_d;
  logic          in_load, in_run, acc, full;
  assign in_load = state_q == S_LOAD;
  assign in_run  = state_q == S_RUN;
  assign acc     = in_load & bus.ld_valid;
  assign full    = ptr_q == AW'(SIZE_WORDS - 1);
  // the pointer holds at the top word so an overflowing image never wraps onto word 0
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (in_load) begin
      if (acc) begin
        ptr_d = full ? ptr_q : ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus.ld_last || full) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          err_d   = !bus.ld_last;
        end
      end
    end else begin
      state_d = bus.load_start ? S_LOAD : in_run ? S_RUN : S_IDLE;
      if (bus.load_start || !in_run) begin
        ptr_d = '0;
        cnt_d = '0;
        err_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  assign bus.ld_ready    = in_load;
  assign bus.mem_we      = acc;
  assign bus.mem_wdata   = acc ? bus.ld_data : '0;
  assign bus.mem_addr    = in_run ? bus.fetch_addr : in_load ? 32'({ptr_q, 2'b00}) : '0;
  assign bus.fetch_valid = in_run & bus.fetch_req;
  assign bus.fetch_data  = in_run ? bus.mem_rdata : '0;
  assign bus.core_stall  = !in_run;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.word_count  = cnt_q;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: directed and random loads checked against a behavioural loader/IMEM model
module tb_imem_loader_ctrl;
  import imem_loader_ctrl_pkg::*;
  localparam int SW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_loader_ctrl_if #(.SIZE_WORDS(SW)) mif ();
  imem_loader_ctrl_if #(.SIZE_WORDS(SW)) aif ();
  imem_loader_ctrl #(.SIZE_WORDS(SW), .AUTO_RUN(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
  imem_loader_ctrl #(.SIZE_WORDS(SW), .AUTO_RUN(1'b1)) u_auto (.clk(clk), .rst_n(rst_n), .bus(aif.slave));
  assign aif.load_start = 1'b0;
  assign aif.ld_valid   = 1'b0;
  assign aif.ld_data    = '0;
  assign aif.ld_last    = 1'b0;
  assign aif.fetch_req  = 1'b1;
  assign aif.fetch_addr = '0;
  assign aif.mem_rdata  = 32'hCAFEF00D;
  // IMEM array: combinational read, synchronous write
  u32_t imem [SW] = '{32'h0, 32'h0, 32'h0, 32'h0};
  always @(posedge clk) if (mif.mem_we) imem[mif.mem_addr[3:2]] <= mif.mem_wdata;
  assign mif.mem_rdata = imem[mif.mem_addr[3:2]];
  // reference: running/loading mode, words loaded so far, expected memory image
  bit   m_run, m_load, m_err, m_done;
  int   m_cnt;
  u32_t m_mem [SW] = '{32'h0, 32'h0, 32'h0, 32'h0};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_load <= 1'b0;
      m_err  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_load) begin
        if (mif.ld_valid) begin
          m_mem[m_cnt] <= mif.ld_data;
          m_cnt <= m_cnt + 1;
          if (mif.ld_last || m_cnt == SW - 1) begin
            m_load <= 1'b0;
            m_run  <= 1'b1;
            m_done <= 1'b1;
            m_err  <= !mif.ld_last;
          end
        end
      end else if (mif.load_start) begin
        m_load <= 1'b1;
        m_run  <= 1'b0;
        m_cnt  <= 0;
        m_err  <= 1'b0;
      end
    end
  end
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit acc;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      acc = m_load && mif.ld_valid;
      chk("core_stall", 32'(mif.core_stall), 32'(!m_run));
      chk("ld_ready", 32'(mif.ld_ready), 32'(m_load));
      chk("mem_we", 32'(mif.mem_we), 32'(acc));
      if (acc) begin
        chk("mem_wdata", mif.mem_wdata, mif.ld_data);
        chk("mem_addr_load", mif.mem_addr, 32'(m_cnt * 4));
      end else if (m_run) chk("mem_addr_run", mif.mem_addr, mif.fetch_addr);
      else if (!m_load) chk("mem_addr_idle", mif.mem_addr, 32'h0);
      chk("fetch_valid", 32'(mif.fetch_valid), 32'(m_run && mif.fetch_req));
      chk("fetch_data", mif.fetch_data, m_run ? m_mem[mif.fetch_addr[3:2]] : 32'h0);
      chk("load_done", 32'(mif.load_done), 32'(m_done));
      chk("load_err", 32'(mif.load_err), 32'(m_err));
      chk("word_count", 32'(mif.word_count), 32'(m_cnt));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_load();
    mif.load_start = 1'b1;
    step();
    mif.load_start = 1'b0;
  endtask
  initial begin
    mif.load_start = 1'b0;
    mif.ld_valid   = 1'b0;
    mif.ld_data    = '0;
    mif.ld_last    = 1'b0;
    mif.fetch_req  = 1'b0;
    mif.fetch_addr = '0;
    step(2);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    mif.fetch_req = 1'b1;
    step(3);
    chk("rst_stall", 32'(mif.core_stall), 32'd1);
    chk("rst_fetch_valid", 32'(mif.fetch_valid), 32'd0);
    chk("rst_fetch_data", mif.fetch_data, 32'h0);
    chk("rst_word_count", 32'(mif.word_count), 32'd0);
    chk("auto_stall", 32'(aif.core_stall), 32'd0);
    chk("auto_fetch_valid", 32'(aif.fetch_valid), 32'd1);
    chk("auto_fetch_data", aif.fetch_data, 32'hCAFEF00D);
    start_load();
    mif.ld_valid = 1'b1;
    mif.ld_data  = 32'h11111111;
    step();
    mif.ld_data  = 32'h22222222;
    #1;
    chk("load_addr_w1", mif.mem_addr, 32'h4);
    chk("load_we_w1", 32'(mif.mem_we), 32'd1);
    step();
    mif.ld_data  = 32'h33333333;
    mif.ld_last  = 1'b1;
    step();
    mif.ld_valid   = 1'b0;
    mif.ld_last    = 1'b0;
    mif.fetch_addr = 32'h8;
    #1;
    chk("load3_done", 32'(mif.load_done), 32'd1);
    chk("load3_count", 32'(mif.word_count), 32'd3);
    chk("load3_stall", 32'(mif.core_stall), 32'd0);
    chk("load3_fetch", mif.fetch_data, 32'h33333333);
    step();
    chk("load3_done_once", 32'(mif.load_done), 32'd0);
    start_load();
    for (int i = 0; i < 3; i++) begin
      mif.ld_valid = 1'b1;
      mif.ld_data  = 32'hA0 + 32'(i);
      mif.ld_last  = i == 2;
      step();
      mif.ld_valid = 1'b0;
      mif.ld_last  = 1'b0;
      if (i < 2) step(2);
    end
    chk("gap_count", 32'(mif.word_count), 32'd3);
    chk("gap_done", 32'(mif.load_done), 32'd1);
    start_load();
    mif.ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mif.ld_data = 32'hB0 + 32'(i);
      step();
    end
    mif.ld_data = 32'hB4;
    #1;
    chk("ovf_err", 32'(mif.load_err), 32'd1);
    chk("ovf_count", 32'(mif.word_count), 32'd4);
    chk("ovf_ready", 32'(mif.ld_ready), 32'd0);
    chk("ovf_done", 32'(mif.load_done), 32'd1);
    chk("ovf_stall", 32'(mif.core_stall), 32'd0);
    step();
    mif.ld_valid   = 1'b0;
    mif.fetch_addr = 32'hC;
    #1;
    chk("ovf_word3", mif.fetch_data, 32'hB3);
    start_load();
    chk("reload_stall", 32'(mif.core_stall), 32'd1);
    mif.ld_valid = 1'b1;
    mif.ld_data  = 32'hDEADBEEF;
    mif.ld_last  = 1'b1;
    step();
    mif.ld_valid   = 1'b0;
    mif.ld_last    = 1'b0;
    mif.fetch_addr = 32'h0;
    #1;
    chk("reload_word0", mif.fetch_data, 32'hDEADBEEF);
    mif.fetch_addr = 32'h6;
    #1;
    chk("reload_word1", mif.fetch_data, 32'hB1);
    chk("reload_err", 32'(mif.load_err), 32'd0);
    chk("reload_count", 32'(mif.word_count), 32'd1);
    start_load();
    mif.ld_valid = 1'b1;
    mif.ld_data  = 32'hC0;
    step();
    mif.ld_data  = 32'hC1;
    step();
    mif.ld_data  = 32'hC2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(mif.core_stall), 32'd1);
    chk("arst_ready", 32'(mif.ld_ready), 32'd0);
    chk("arst_we", 32'(mif.mem_we), 32'd0);
    chk("arst_count", 32'(mif.word_count), 32'd0);
    step(2);
    rst_n = 1'b1;
    mif.ld_valid = 1'b0;
    step(3);
    chk("post_rst_stall", 32'(mif.core_stall), 32'd1);
    chk("post_rst_fetch_valid", 32'(mif.fetch_valid), 32'd0);
    start_load();
    mif.ld_valid = 1'b1;
    mif.ld_data  = 32'hD0;
    mif.ld_last  = 1'b1;
    step();
    mif.ld_valid   = 1'b0;
    mif.ld_last    = 1'b0;
    mif.fetch_addr = 32'h4;
    #1;
    chk("post_rst_run", 32'(mif.core_stall), 32'd0);
    chk("post_rst_word1", mif.fetch_data, 32'hC1);
    for (int i = 0; i < 400; i++) begin
      mif.load_start = $urandom_range(15) == 0;
      mif.ld_valid   = 1'($urandom_range(1));
      mif.ld_last    = $urandom_range(3) == 0;
      mif.ld_data    = $urandom;
      mif.fetch_req  = 1'($urandom_range(1));
      mif.fetch_addr = 32'($urandom_range(15));
      if ($urandom_range(99) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else step();
    end
    mif.load_start = 1'b0;
    mif.ld_valid   = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
